// File: rtl/game_pkg.sv
// Shared game constants and camera FSM state type, used by camera_tracker and the pixel generator.
package game_pkg;

  localparam int PHY_WIDTH    = 16;
  localparam int BLOCK_WIDTH  = 480;
  localparam int CHAR_WIDTH_Y = 32;
  localparam int CAM_WIDTH    = 5;
  localparam int HYST_PX      = 16;

  // Remainder-width versions of the constants so the datapath compares equal widths.
  localparam logic [PHY_WIDTH:0]   BLOCK_REM  = (PHY_WIDTH+1)'(BLOCK_WIDTH);
  localparam logic [PHY_WIDTH:0]   CENTRE_OFS = (PHY_WIDTH+1)'(CHAR_WIDTH_Y / 2);
  localparam logic [PHY_WIDTH:0]   HYST_UP    = (PHY_WIDTH+1)'(HYST_PX);
  localparam logic [PHY_WIDTH:0]   HYST_DOWN  = (PHY_WIDTH+1)'(BLOCK_WIDTH - HYST_PX);
  localparam logic [CAM_WIDTH-1:0] CAM_MAX    = {CAM_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    COMMIT = 2'd2
  } cam_state_t;

endpackage

// File: rtl/block_index_div.sv
// Iterative restoring divide by the constant BLOCK_WIDTH, one subtract per step,
// quotient saturating at CAM_MAX.
module block_index_div
  import game_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 step,
  input  logic [PHY_WIDTH:0]   dividend,
  output logic [CAM_WIDTH-1:0] q,
  output logic [PHY_WIDTH:0]   rem,
  output logic                 done
);

  logic can_sub;

  // Once q reaches CAM_MAX the loop stops and rem is left as-is (don't-care).
  assign can_sub = (rem >= BLOCK_REM) && (q != CAM_MAX);
  assign done    = !can_sub;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      rem <= '0;
    end else if (start) begin
      q   <= '0;
      rem <= dividend;
    end else if (step && can_sub) begin
      q   <= q + 1'b1;
      rem <= rem - BLOCK_REM;
    end
  end

endmodule

// File: rtl/camera_tracker.sv
// Per-frame camera block index: divide character centre by BLOCK_WIDTH, commit in blanking.
// Optional hysteresis at block seams when CAMERA_HYST_EN is defined.
module camera_tracker
  import game_pkg::*;
(
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 frame_start,
  input  logic [PHY_WIDTH-1:0] char_abs_y,
  output logic [CAM_WIDTH-1:0] camera_y,
  output logic                 cam_changed,
  output logic                 busy,
  output logic                 overrun,
  output cam_state_t           dbg_state
);

  cam_state_t           state_q, state_d;
  logic                 accept;
  logic [PHY_WIDTH:0]   centre;
  logic [CAM_WIDTH-1:0] div_q;
  logic [PHY_WIDTH:0]   div_rem;
  logic                 div_done;
  logic [CAM_WIDTH-1:0] next_idx;

  assign accept    = frame_start && (state_q == IDLE);
  assign centre    = {1'b0, char_abs_y} + CENTRE_OFS;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  block_index_div u_div (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .start    (accept),
    .step     (state_q == DIVIDE),
    .dividend (centre),
    .q        (div_q),
    .rem      (div_rem),
    .done     (div_done)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = DIVIDE;
      DIVIDE:  if (div_done) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef CAMERA_HYST_EN
  // One-block moves need the centre to be HYST_PX inside the new block; bigger jumps and saturation are immediate.
  always_comb begin
    next_idx = div_q;
    if (div_q != CAM_MAX) begin
      if ({1'b0, div_q} == {1'b0, camera_y} + 6'd1) begin
        if (div_rem < HYST_UP) next_idx = camera_y;
      end else if ({1'b0, div_q} + 6'd1 == {1'b0, camera_y}) begin
        if (div_rem >= HYST_DOWN) next_idx = camera_y;
      end
    end
  end
`else
  logic unused_rem;
  assign unused_rem = ^div_rem;
  assign next_idx   = div_q;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      camera_y    <= '0;
      cam_changed <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      cam_changed <= 1'b0;
      overrun     <= frame_start && (state_q != IDLE);
      if ((state_q == COMMIT) && (next_idx != camera_y)) begin
        camera_y    <= next_idx;
        cam_changed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_camera_tracker.sv
// Self-checking bench for camera_tracker: directed seam/saturation/overrun/reset cases plus random frames.
module tb_camera_tracker;
  import game_pkg::*;

  logic                 sys_clk;
  logic                 sys_rst;
  logic                 frame_start;
  logic [PHY_WIDTH-1:0] char_abs_y;
  logic [CAM_WIDTH-1:0] camera_y;
  logic                 cam_changed;
  logic                 busy;
  logic                 overrun;
  cam_state_t           dbg_state;

  int n_checks;
  int n_errors;
  int cam_model;
  logic [CAM_WIDTH-1:0] exp_q[$];

  camera_tracker dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .frame_start (frame_start),
    .char_abs_y  (char_abs_y),
    .camera_y    (camera_y),
    .cam_changed (cam_changed),
    .busy        (busy),
    .overrun     (overrun),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: centre / BLOCK_WIDTH, capped, then the seam rule
  function automatic int model_q(input int y);
    int q;
    q = (y + CHAR_WIDTH_Y / 2) / BLOCK_WIDTH;
    return (q > 31) ? 31 : q;
  endfunction

  function automatic int model_next(input int y, input int cur);
    int c, q, r;
    c = y + CHAR_WIDTH_Y / 2;
    q = model_q(y);
    r = c - q * BLOCK_WIDTH;
`ifdef CAMERA_HYST_EN
    if (q == 31) return q;
    if (q == cur + 1) return (r >= HYST_PX) ? q : cur;
    if (q == cur - 1) return (r < BLOCK_WIDTH - HYST_PX) ? q : cur;
    return q;
`else
    r = r + cur; // hysteresis inputs unused in this build
    return q;
`endif
  endfunction

  // driver: one frame; ovr_gap>0 fires a second frame_start sampled that many edges later
  task automatic run_frame(input int y, input int ovr_gap);
    int k, old;
    logic [CAM_WIDTH-1:0] exp;
    k   = model_q(y);
    old = cam_model;
    exp_q.push_back(CAM_WIDTH'(model_next(y, cam_model)));
    @(negedge sys_clk);
    check_eq("idle_before_frame", busy, 0);
    frame_start = 1'b1;
    char_abs_y  = PHY_WIDTH'(y);
    @(negedge sys_clk);
    frame_start = 1'b0;
    char_abs_y  = PHY_WIDTH'($urandom);
    for (int c = 1; c <= k + 2; c++) begin
      if (c == ovr_gap) begin
        frame_start = 1'b1;
        char_abs_y  = PHY_WIDTH'($urandom);
      end
      @(posedge sys_clk);
      #1;
      if (c == ovr_gap) begin
        frame_start = 1'b0;
        check_eq("overrun_pulse", overrun, 1);
      end else begin
        check_eq("overrun_quiet", overrun, 0);
      end
      if (c < k + 2) begin
        check_eq("camera_hold", camera_y, old);
        check_eq("busy_during", busy, 1);
        check_eq("changed_quiet", cam_changed, 0);
      end else begin
        exp = exp_q.pop_front();
        check_eq("camera_commit", camera_y, exp);
        check_eq("changed_pulse", cam_changed, (int'(exp) != old) ? 1 : 0);
        check_eq("busy_fall", busy, 0);
        cam_model = int'(exp);
      end
    end
    @(posedge sys_clk);
    #1;
    check_eq("changed_one_cycle", cam_changed, 0);
    check_eq("no_reprocess", busy, 0);
    check_eq("overrun_one_cycle", overrun, 0);
    check_eq("camera_stable", camera_y, cam_model);
  endtask

  task automatic reset_mid_divide();
    @(negedge sys_clk);
    frame_start = 1'b1;
    char_abs_y  = 16'd5000;
    @(negedge sys_clk);
    frame_start = 1'b0;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #2;
    check_eq("in_divide", busy, 1);
    sys_rst = 1'b1;
    #1;
    check_eq("rst_camera", camera_y, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_changed", cam_changed, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_state", dbg_state, IDLE);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    cam_model = 0;
    exp_q.delete();
    repeat (5) begin
      @(posedge sys_clk);
      #1;
      check_eq("post_rst_idle", busy, 0);
      check_eq("post_rst_camera", camera_y, 0);
    end
  endtask

  initial begin
    int y, k, gap;
    n_checks    = 0;
    n_errors    = 0;
    cam_model   = 0;
    sys_rst     = 1'b1;
    frame_start = 1'b0;
    char_abs_y  = '0;
    #1;
    check_eq("init_camera", camera_y, 0);
    check_eq("init_busy", busy, 0);
    check_eq("init_changed", cam_changed, 0);
    check_eq("init_overrun", overrun, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;

    reset_mid_divide();

    run_frame(1000, 0);      // q=2
    run_frame(1000, 0);      // unchanged
    run_frame(16'hFFFA, 0);  // saturate at 31
    run_frame(1000, 3);      // overrun, first sample commits
    run_frame(5000, 12);     // frame_start during COMMIT is ignored

    reset_mid_divide();
    run_frame(450, 0);
    run_frame(470, 0);
    run_frame(490, 0);
    run_frame(440, 0);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) y = int'($urandom_range(0, 65535));
      else y = cam_model * BLOCK_WIDTH + int'($urandom_range(0, 1000)) - 500;
      if (y < 0) y = 0;
      if (y > 65535) y = 65535;
      k = model_q(y);
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, k + 2)) : 0;
      run_frame(y, gap);
    end

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
